// File: rtl/turbo_encoder_using_cia.sv
// Rate-1/3 turbo encoder for one eCall frame: two 8-state RSCs, recursive QPP (CIA) interleaver.
// Define TE_VALID_OUT_EN to add the out_TE_valid output strobe.
module turbo_encoder_using_cia #(
  parameter int K  = 1148,
  parameter int F1 = 3,
  parameter int F2 = 574
) (
  input  logic clk,
  input  logic rst,
  input  logic ack,
  input  logic mode,
  input  logic in_MSD_CRC,
  output logic out_TE_data
`ifdef TE_VALID_OUT_EN
  ,
  output logic out_TE_valid
`endif
);

  localparam int AW = $clog2(K);
  localparam logic [AW-1:0] LAST_C   = AW'(K - 1);
  localparam logic [AW:0]   K_C      = (AW+1)'(K);
  localparam logic [AW-1:0] G0_C     = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] G_STEP_C = AW'((2 * F2) % K);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ENC, S_TAIL} state_e;
  typedef enum logic [2:0] {OP_NONE, OP_X, OP_Z1, OP_Z2, OP_TX1, OP_TZ1, OP_TX2, OP_TZ2} op_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pi_q, pi_d;
  logic [AW-1:0] g_q, g_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    tail_q, tail_d;
  op_e           op_a_q, op_a_d;
  op_e           op_b_q, op_b_d;
  logic [2:0]    rsc1_q, rsc1_d;
  logic [2:0]    rsc2_q, rsc2_d;
  logic          out_q, out_d;
  logic          rd_q;

  logic [AW:0]   pi_sum, g_sum;
  logic [AW-1:0] pi_adv, g_adv;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    step1, step2;

  logic buf_mem [K];

  // State s = {s1,s2,s3}; returns {z, next state}. term forces u = feedback (trellis termination).
  function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic u, input logic term);
    logic fb;
    logic a;
    fb = s[1] ^ s[0];
    a  = term ? 1'b0 : (u ^ fb);
    return {a ^ s[2] ^ s[0], a, s[2], s[1]};
  endfunction

  assign wr_en   = ack || (state_q == S_LOAD);
  assign wr_addr = ack ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[wr_addr] <= in_MSD_CRC;
    end
    rd_q <= buf_mem[addr_q];
  end

  // Each mod is a single compare-and-subtract since both operands are already < K.
  always_comb begin
    pi_sum = {1'b0, pi_q} + {1'b0, g_q};
    g_sum  = {1'b0, g_q} + {1'b0, G_STEP_C};
    pi_adv = (pi_sum >= K_C) ? AW'(pi_sum - K_C) : pi_sum[AW-1:0];
    g_adv  = (g_sum  >= K_C) ? AW'(g_sum  - K_C) : g_sum[AW-1:0];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    pi_d    = pi_q;
    g_d     = g_q;
    phase_d = phase_q;
    tail_d  = tail_q;
    addr_d  = addr_q;
    op_a_d  = OP_NONE;
    case (state_q)
      S_LOAD: begin
        if (cnt_q == LAST_C) begin
          state_d = S_ENC;
          cnt_d   = '0;
          phase_d = 2'd0;
          pi_d    = '0;
          g_d     = G0_C;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ENC: begin
        op_a_d = (phase_q == 2'd0) ? OP_X : ((phase_q == 2'd1) ? OP_Z1 : OP_Z2);
        addr_d = (phase_q == 2'd2) ? pi_q : cnt_q;
        if (phase_q == 2'd2) begin
          pi_d = pi_adv;
          g_d  = g_adv;
        end
        // Parallel: phase is inner (x,z,z' per k). Serial: k is inner, phase selects the pass.
        if (mode_q) begin
          if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            if (cnt_q == LAST_C) begin
              state_d = S_TAIL;
              tail_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          if (cnt_q == LAST_C) begin
            cnt_d = '0;
            if (phase_q == 2'd2) begin
              state_d = S_TAIL;
              tail_d  = '0;
            end else begin
              phase_d = phase_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (tail_q < 4'd6) begin
          op_a_d = tail_q[0] ? OP_TZ1 : OP_TX1;
        end else begin
          op_a_d = tail_q[0] ? OP_TZ2 : OP_TX2;
        end
        if (tail_q == 4'd11) begin
          state_d = S_IDLE;
        end else begin
          tail_d = tail_q + 4'd1;
        end
      end
      default: ;
    endcase
    if (ack) begin
      state_d = S_LOAD;
      mode_d  = mode;
      cnt_d   = {{(AW-1){1'b0}}, 1'b1};
      op_a_d  = OP_NONE;
    end
  end

  assign step1 = rsc_step(rsc1_q, rd_q, op_b_q == OP_TZ1);
  assign step2 = rsc_step(rsc2_q, rd_q, op_b_q == OP_TZ2);

  always_comb begin
    out_d  = 1'b0;
    rsc1_d = rsc1_q;
    rsc2_d = rsc2_q;
    op_b_d = op_a_q;
    case (op_b_q)
      OP_X:   out_d = rd_q;
      OP_Z1, OP_TZ1: begin
        out_d  = step1[3];
        rsc1_d = step1[2:0];
      end
      OP_Z2, OP_TZ2: begin
        out_d  = step2[3];
        rsc2_d = step2[2:0];
      end
      OP_TX1: out_d = rsc1_q[1] ^ rsc1_q[0];
      OP_TX2: out_d = rsc2_q[1] ^ rsc2_q[0];
      default: ;
    endcase
    // A new block flushes everything still in flight.
    if (ack) begin
      out_d  = 1'b0;
      rsc1_d = '0;
      rsc2_d = '0;
      op_b_d = OP_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      pi_q    <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      phase_q <= 2'd0;
      tail_q  <= '0;
      op_a_q  <= OP_NONE;
      op_b_q  <= OP_NONE;
      rsc1_q  <= '0;
      rsc2_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      tail_q  <= tail_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rsc1_q  <= rsc1_d;
      rsc2_q  <= rsc2_d;
      out_q   <= out_d;
    end
  end

  assign out_TE_data = out_q;

`ifdef TE_VALID_OUT_EN
  logic valid_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= !ack && (op_b_q != OP_NONE);
    end
  end
  assign out_TE_valid = valid_q;
`endif

endmodule

// File: tb/tb_turbo_encoder_using_cia.sv
// Scoreboard bench for turbo_encoder_using_cia: stimulus pushes expected coded streams,
// a negedge monitor captures the DUT output window and compares; idle cycles must read 0.
module tb_turbo_encoder_using_cia;

  localparam int K = 1148;
  localparam int N = 3 * K + 12;

  logic clk;
  logic rst;
  logic ack;
  logic mode;
  logic in_bit;
  logic out_data;
`ifdef TE_VALID_OUT_EN
  logic out_valid;
`endif

  turbo_encoder_using_cia dut (
    .clk        (clk),
    .rst        (rst),
    .ack        (ack),
    .mode       (mode),
    .in_MSD_CRC (in_bit),
    .out_TE_data(out_data)
`ifdef TE_VALID_OUT_EN
    ,
    .out_TE_valid(out_valid)
`endif
  );

  typedef struct {
    string          name;
    int             start;
    int             len;
    bit             m;
    logic [K-1:0]   c;
    logic [N-1:0]   e;
    int             nspot;
    bit [3:0][11:0] sidx;
    bit [3:0]       sval;
  } rec_t;

  rec_t         q[$];
  rec_t         cur;
  logic [N-1:0] cap;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  collecting = 0;
  int  idle_n = 0;
  int  idle_bad = 0;
  int  idle_first = -1;
  int  valid_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, detail);
  endtask

  function automatic int pi_of(input int i);
    longint t;
    t = 64'd3 * longint'(i) + 64'd574 * longint'(i) * longint'(i);
    return int'(t % 64'd1148);
  endfunction

  // Reference encoder written straight from the RSC equations.
  function automatic logic [N-1:0] model(input logic [K-1:0] c, input bit m);
    logic [N-1:0] e;
    bit s1a, s2a, s3a, s1b, s2b, s3b, u1, u2, aa, ab, za, zb;
    e = '0;
    s1a = 0; s2a = 0; s3a = 0; s1b = 0; s2b = 0; s3b = 0;
    for (int k = 0; k < K; k++) begin
      u1 = c[k];
      u2 = c[pi_of(k)];
      aa = u1 ^ s2a ^ s3a; za = aa ^ s1a ^ s3a;
      s3a = s2a; s2a = s1a; s1a = aa;
      ab = u2 ^ s2b ^ s3b; zb = ab ^ s1b ^ s3b;
      s3b = s2b; s2b = s1b; s1b = ab;
      if (m) begin
        e[3*k] = u1; e[3*k+1] = za; e[3*k+2] = zb;
      end else begin
        e[k] = u1; e[K+k] = za; e[2*K+k] = zb;
      end
    end
    for (int t = 0; t < 3; t++) begin
      e[3*K+2*t]   = s2a ^ s3a;
      e[3*K+2*t+1] = s1a ^ s3a;
      s3a = s2a; s2a = s1a; s1a = 0;
    end
    for (int t = 0; t < 3; t++) begin
      e[3*K+6+2*t]   = s2b ^ s3b;
      e[3*K+6+2*t+1] = s1b ^ s3b;
      s3b = s2b; s2b = s1b; s1b = 0;
    end
    return e;
  endfunction

  task automatic check_block(input rec_t r, input logic [N-1:0] got);
    int lo, hi, nerr, first;
    logic gb, eb;
    $display("block %s mode=%0d bits=%0d", r.name, r.m, r.len);
    for (int s = 0; s < 4; s++) begin
      lo = s * K;
      hi = (s == 3) ? N : lo + K;
      if (hi > r.len) hi = r.len;
      if (lo < hi) begin
        nerr = 0; first = -1; gb = 0; eb = 0;
        for (int i = lo; i < hi; i++) begin
          if (got[i] !== r.e[i]) begin
            if (first < 0) begin first = i; gb = got[i]; eb = r.e[i]; end
            nerr++;
          end
        end
        chk($sformatf("%s/seg%0d", r.name, s), nerr == 0,
            $sformatf("%0d wrong bits in [%0d,%0d), first at %0d got %b required %b",
                      nerr, lo, hi, first, gb, eb));
      end
    end
    if (r.len == N) begin
      nerr = 0; first = -1;
      for (int k = 0; k < K; k++) begin
        gb = r.m ? got[3*k] : got[k];
        if (gb !== r.c[k]) begin
          if (first < 0) first = k;
          nerr++;
        end
      end
      chk($sformatf("%s/systematic", r.name), nerr == 0,
          $sformatf("%0d systematic bits differ from input, first k=%0d; required 0", nerr, first));
    end
    for (int j = 0; j < r.nspot; j++) begin
      chk($sformatf("%s/bit%0d", r.name, int'(r.sidx[j])), got[r.sidx[j]] === r.sval[j],
          $sformatf("got %b required %b", got[r.sidx[j]], r.sval[j]));
    end
  endtask

  // Monitor: captures len bits starting at the scheduled cycle, otherwise output must be 0.
  initial begin
    int pos;
    pos = 0;
    forever begin
      @(negedge clk);
      if (!collecting && q.size() > 0 && cyc == q[0].start) begin
        cur = q.pop_front();
        collecting = 1;
        pos = 0;
        cap = '0;
      end
      if (collecting) begin
        cap[pos] = out_data;
`ifdef TE_VALID_OUT_EN
        if (out_valid !== 1'b1) valid_bad++;
`endif
        pos++;
        if (pos == cur.len) begin
          collecting = 0;
          check_block(cur, cap);
        end
      end else begin
        idle_n++;
        if (out_data !== 1'b0) begin
          if (idle_first < 0) idle_first = cyc;
          idle_bad++;
        end
`ifdef TE_VALID_OUT_EN
        if (out_valid !== 1'b0) valid_bad++;
`endif
      end
    end
  end

  task automatic drive_load(input logic [K-1:0] c, input bit m, input int nbits, output int e0);
    @(negedge clk);
    ack = 1; mode = m; in_bit = c[0];
    e0 = cyc + 1;
    for (int i = 1; i < nbits; i++) begin
      @(negedge clk);
      ack = 0; mode = 0; in_bit = c[i];
    end
  endtask

  task automatic run_block(input string nm, input logic [K-1:0] c, input bit m, input int len,
                           input int nspot, input bit [3:0][11:0] sidx, input bit [3:0] sval,
                           output int start);
    rec_t r;
    int e0;
    drive_load(c, m, K, e0);
    r.name = nm; r.start = e0 + K + 2; r.len = len; r.m = m; r.c = c;
    r.e = model(c, m); r.nspot = nspot; r.sidx = sidx; r.sval = sval;
    q.push_back(r);
    start = r.start;
    @(negedge clk);
    ack = 0; in_bit = 0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((q.size() != 0 || collecting) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [K-1:0] zeros, imp, b577, pat, pat_n;
    int s, dummy;
    rst = 0; ack = 0; mode = 0; in_bit = 0;
    zeros = '0;
    imp = '0; imp[0] = 1'b1;
    b577 = '0; b577[577] = 1'b1;
    pat = {{110{10'h2F6}}, 48'hABCDEFABCDEF};
    pat_n = ~pat;
    repeat (4) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);

    run_block("t1_zero_m0", zeros, 0, N, 4, {12'd3455, 12'd2296, 12'd1148, 12'd0}, 4'b0000, s);
    wait_done();
    run_block("t2_imp_m0", imp, 0, N, 4, {12'd1150, 12'd1148, 12'd1, 12'd0}, 4'b1101, s);
    wait_done();
    run_block("t2_imp_m1", imp, 1, N, 4, {12'd3, 12'd2, 12'd1, 12'd0}, 4'b0111, s);
    wait_done();
    run_block("t3_cia_m1", b577, 1, N, 4, {12'd1731, 12'd5, 12'd2, 12'd0}, 4'b1100, s);
    wait_done();
    run_block("t4_pat_m0", pat, 0, N, 0, '0, '0, s);
    wait_done();
    run_block("t4_pat_m1", pat, 1, N, 0, '0, '0, s);
    wait_done();

    drive_load(pat, 0, 500, dummy);
    run_block("t5_reload_m1", pat_n, 1, N, 0, '0, '0, s);
    wait_done();

    run_block("t6_rst_m1", pat, 1, 200, 0, '0, '0, s);
    while (cyc < s + 199) @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    repeat (100) @(negedge clk);
    run_block("t6_after_rst_m1", imp, 1, N, 4, {12'd3, 12'd2, 12'd1, 12'd0}, 4'b0111, s);
    wait_done();

    repeat (10) @(negedge clk);
    chk("idle_zero", idle_bad == 0,
        $sformatf("%0d of %0d idle cycles non-zero, first at cycle %0d; required 0", idle_bad, idle_n, idle_first));
`ifdef TE_VALID_OUT_EN
    chk("valid_window", valid_bad == 0,
        $sformatf("%0d cycles with wrong out_TE_valid; required 0", valid_bad));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
